// File: rtl/alu_result_display.sv
// alu_result_display: accepts a sign-magnitude ALU result and its flags over valid/ready,
// converts the magnitude to tens/units and scans it onto a 4-digit active-low 7-segment display.
// Optional feature macro: DISP_BLINK_EN (blinks the "Err" display while a divide-by-zero is shown).
module alu_result_display #(
    parameter logic [15:0] REFRESH_DIV = 16'd50000,
    parameter logic [23:0] BLINK_DIV   = 24'd5000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       res_valid,
    output logic       res_ready,
    input  logic [4:0] c,
    input  logic       zeroflag,
    input  logic       signflag,
    input  logic       divbyzeroflag,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       zero_led,
    output logic       sign_led
);

    localparam int unsigned MAG_W  = 4;
    localparam int unsigned SCAN_W = 16;
    localparam int unsigned IDX_W  = 2;

    localparam logic [6:0] GLYPH_MINUS = 7'b0111111;
    localparam logic [6:0] GLYPH_E     = 7'b0000110;
    localparam logic [6:0] GLYPH_R     = 7'b0101111;
    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        SHOW    = 2'd2
    } state_e;

    // Elaboration guards on the timing parameters
    if (REFRESH_DIV < 16'd2) begin : g_bad_refresh
        $error("REFRESH_DIV must be at least 2");
    end
    if (BLINK_DIV < 24'd1) begin : g_bad_blink
        $error("BLINK_DIV must be at least 1");
    end

    state_e             state_q, state_d;
    logic               ready_q, ready_d;
    logic               sign_q, sign_d;
    logic [MAG_W-1:0]   mag_q, mag_d;
    logic               tens_q, tens_d;
    logic               zf_q, zf_d;
    logic               sf_q, sf_d;
    logic               dbz_q, dbz_d;
    logic               disp_show_q, disp_show_d;
    logic               disp_neg_q, disp_neg_d;
    logic               disp_tens_q, disp_tens_d;
    logic [MAG_W-1:0]   disp_units_q, disp_units_d;
    logic               disp_dbz_q, disp_dbz_d;
    logic [SCAN_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [3:0]         an_q, an_d;
    logic [6:0]         seg_q, seg_d;
    logic               xfer;
    logic               blink_off;

    // Decimal digit to active-low {g,f,e,d,c,b,a}
    function automatic logic [6:0] digit_glyph(input logic [MAG_W-1:0] v);
        logic [6:0] g;
        case (v)
            4'd0:    g = 7'b1000000;
            4'd1:    g = 7'b1111001;
            4'd2:    g = 7'b0100100;
            4'd3:    g = 7'b0110000;
            4'd4:    g = 7'b0011001;
            4'd5:    g = 7'b0010010;
            4'd6:    g = 7'b0000010;
            4'd7:    g = 7'b1111000;
            4'd8:    g = 7'b0000000;
            4'd9:    g = 7'b0010000;
            default: g = GLYPH_BLANK;
        endcase
        return g;
    endfunction

    assign xfer = res_valid & ready_q;

`ifdef DISP_BLINK_EN
    logic [23:0] blink_cnt_q, blink_cnt_d;
    logic        blink_ph_q, blink_ph_d;

    // Blink phase timer, restarted in the lit phase on every accepted result
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        blink_ph_d  = blink_ph_q;
        if (xfer) begin
            blink_cnt_d = 24'd0;
            blink_ph_d  = 1'b0;
        end else if (blink_cnt_q == BLINK_DIV - 24'd1) begin
            blink_cnt_d = 24'd0;
            blink_ph_d  = ~blink_ph_q;
        end else begin
            blink_cnt_d = blink_cnt_q + 24'd1;
        end
    end

    // Blink timer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt_q <= 24'd0;
            blink_ph_q  <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_ph_q  <= blink_ph_d;
        end
    end

    assign blink_off = blink_ph_d & disp_dbz_d & disp_show_d;
`else
    assign blink_off = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, conversion datapath, scan and display encoding
    always_comb begin
        state_d      = state_q;
        sign_d       = sign_q;
        mag_d        = mag_q;
        tens_d       = tens_q;
        zf_d         = zf_q;
        sf_d         = sf_q;
        dbz_d        = dbz_q;
        disp_show_d  = disp_show_q;
        disp_neg_d   = disp_neg_q;
        disp_tens_d  = disp_tens_q;
        disp_units_d = disp_units_q;
        disp_dbz_d   = disp_dbz_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        an_d         = 4'b1111;
        seg_d        = GLYPH_BLANK;

        case (state_q)
            IDLE, SHOW: begin
                if (xfer) begin
                    state_d = CONVERT;
                    sign_d  = c[4];
                    mag_d   = c[3:0];
                    tens_d  = 1'b0;
                    zf_d    = zeroflag;
                    sf_d    = signflag;
                    dbz_d   = divbyzeroflag;
                end
            end
            CONVERT: begin
                if (mag_q >= 4'd10) begin
                    mag_d  = mag_q - 4'd10;
                    tens_d = 1'b1;
                end else begin
                    state_d      = SHOW;
                    disp_show_d  = 1'b1;
                    disp_neg_d   = sign_q & ((mag_q != 4'd0) | tens_q);
                    disp_tens_d  = tens_q;
                    disp_units_d = mag_q;
                    disp_dbz_d   = dbz_q;
                end
            end
            default: state_d = IDLE;
        endcase

        ready_d = (state_d != CONVERT);

        if (cnt_q == REFRESH_DIV - 16'd1) begin
            cnt_d = 16'd0;
            idx_d = idx_q + 2'd1;
        end else begin
            cnt_d = cnt_q + 16'd1;
        end

        if (disp_show_d && !blink_off) begin
            an_d[2'(2'd3 - idx_d)] = 1'b0;
        end

        if (disp_show_d) begin
            case (idx_d)
                2'd0: seg_d = disp_dbz_d ? GLYPH_E :
                              (disp_neg_d ? GLYPH_MINUS : GLYPH_BLANK);
                2'd1: seg_d = disp_dbz_d ? GLYPH_R :
                              (disp_tens_d ? digit_glyph(4'd1) : GLYPH_BLANK);
                2'd2: seg_d = disp_dbz_d ? GLYPH_R : digit_glyph(disp_units_d);
                default: seg_d = GLYPH_BLANK;
            endcase
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_q      <= 1'b1;
            sign_q       <= 1'b0;
            mag_q        <= 4'd0;
            tens_q       <= 1'b0;
            zf_q         <= 1'b0;
            sf_q         <= 1'b0;
            dbz_q        <= 1'b0;
            disp_show_q  <= 1'b0;
            disp_neg_q   <= 1'b0;
            disp_tens_q  <= 1'b0;
            disp_units_q <= 4'd0;
            disp_dbz_q   <= 1'b0;
            cnt_q        <= 16'd0;
            idx_q        <= 2'd0;
            an_q         <= 4'b1111;
            seg_q        <= GLYPH_BLANK;
        end else begin
            ready_q      <= ready_d;
            sign_q       <= sign_d;
            mag_q        <= mag_d;
            tens_q       <= tens_d;
            zf_q         <= zf_d;
            sf_q         <= sf_d;
            dbz_q        <= dbz_d;
            disp_show_q  <= disp_show_d;
            disp_neg_q   <= disp_neg_d;
            disp_tens_q  <= disp_tens_d;
            disp_units_q <= disp_units_d;
            disp_dbz_q   <= disp_dbz_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
        end
    end

    assign res_ready = ready_q;
    assign an        = an_q;
    assign seg       = seg_q;
    assign zero_led  = zf_q;
    assign sign_led  = sf_q;

endmodule

// File: tb/tb_alu_result_display.sv
// Directed bench for alu_result_display with REFRESH_DIV=4, BLINK_DIV=8.
module tb_alu_result_display;

    localparam logic [6:0] G0 = 7'b1000000;
    localparam logic [6:0] G1 = 7'b1111001;
    localparam logic [6:0] G2 = 7'b0100100;
    localparam logic [6:0] G3 = 7'b0110000;
    localparam logic [6:0] G5 = 7'b0010010;
    localparam logic [6:0] GM = 7'b0111111;
    localparam logic [6:0] GE = 7'b0000110;
    localparam logic [6:0] GR = 7'b0101111;
    localparam logic [6:0] GB = 7'b1111111;

`ifdef DISP_BLINK_EN
    localparam int unsigned EXP_OFF = 8;
`else
    localparam int unsigned EXP_OFF = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       res_valid;
    logic       res_ready;
    logic [4:0] c;
    logic       zeroflag;
    logic       signflag;
    logic       divbyzeroflag;
    logic [3:0] an;
    logic [6:0] seg;
    logic       zero_led;
    logic       sign_led;

    int checks = 0;
    int errors = 0;
    logic [6:0] cap_seg [4];
    logic [3:0] cap_found;
    logic       cap_bad_an;

    alu_result_display #(
        .REFRESH_DIV(16'd4),
        .BLINK_DIV  (24'd8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .c            (c),
        .zeroflag     (zeroflag),
        .signflag     (signflag),
        .divbyzeroflag(divbyzeroflag),
        .an           (an),
        .seg          (seg),
        .zero_led     (zero_led),
        .sign_led     (sign_led)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one result for a single accepting edge; returns cycles ready stayed low
    task automatic send(input logic [4:0] cv, input logic zf, input logic sf, input logic dbz,
                        output int lat);
        @(negedge clk);
        chk("ready_before_send", 32'(res_ready), 32'd1);
        res_valid = 1'b1; c = cv; zeroflag = zf; signflag = sf; divbyzeroflag = dbz;
        @(posedge clk);
        @(negedge clk);
        res_valid = 1'b0;
        lat = 0;
        while (!res_ready && lat < 20) begin
            lat++;
            @(negedge clk);
        end
    endtask

    // Record the segment pattern seen under each anode during one scan sweep
    task automatic capture();
        cap_found  = 4'b0000;
        cap_bad_an = 1'b0;
        for (int n = 0; n < 64 && cap_found != 4'b1111; n++) begin
            @(negedge clk);
            case (an)
                4'b0111: begin cap_seg[0] = seg; cap_found[0] = 1'b1; end
                4'b1011: begin cap_seg[1] = seg; cap_found[1] = 1'b1; end
                4'b1101: begin cap_seg[2] = seg; cap_found[2] = 1'b1; end
                4'b1110: begin cap_seg[3] = seg; cap_found[3] = 1'b1; end
                4'b1111: ;
                default: cap_bad_an = 1'b1;
            endcase
        end
        chk("scan_all_digits", 32'(cap_found), 32'hF);
        chk("an_one_hot_low", 32'(cap_bad_an), 32'd0);
    endtask

    task automatic check_digits(input string tag, input logic [6:0] e3, input logic [6:0] e2,
                                input logic [6:0] e1, input logic [6:0] e0);
        capture();
        chk({tag, "_an3"}, 32'(cap_seg[0]), 32'(e3));
        chk({tag, "_an2"}, 32'(cap_seg[1]), 32'(e2));
        chk({tag, "_an1"}, 32'(cap_seg[2]), 32'(e1));
        chk({tag, "_an0"}, 32'(cap_seg[3]), 32'(e0));
    endtask

    initial begin
        int lat;
        int off_cnt;
        logic idle_lit;

        rst = 1'b1; res_valid = 1'b0; c = 5'd0;
        zeroflag = 1'b0; signflag = 1'b0; divbyzeroflag = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_ready", 32'(res_ready), 32'd1);
        chk("rst_leds", 32'({zero_led, sign_led}), 32'd0);
        rst = 1'b0;

        idle_lit = 1'b0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (an != 4'b1111) idle_lit = 1'b1;
        end
        chk("idle_blank", 32'(idle_lit), 32'd0);

        // +5
        send(5'b00101, 1'b0, 1'b0, 1'b0, lat);
        chk("lat_5", 32'(lat), 32'd1);
        check_digits("pos5", GB, GB, G5, GB);
        chk("leds_5", 32'({zero_led, sign_led}), 32'd0);

        // -12
        send(5'b11100, 1'b0, 1'b1, 1'b0, lat);
        chk("lat_m12", 32'(lat), 32'd2);
        check_digits("neg12", GM, G1, G2, GB);
        chk("leds_m12", 32'({zero_led, sign_led}), 32'b01);

        // negative zero
        send(5'b10000, 1'b1, 1'b1, 1'b0, lat);
        chk("lat_m0", 32'(lat), 32'd1);
        check_digits("negzero", GB, GB, G0, GB);
        chk("leds_m0", 32'({zero_led, sign_led}), 32'b11);

        // divide by zero; lit/dark pattern counted from the cycle SHOW starts
        send(5'b00000, 1'b0, 1'b0, 1'b1, lat);
        chk("lat_dbz", 32'(lat), 32'd1);
        off_cnt = 0;
        for (int n = 1; n < 24; n++) begin
            if (an == 4'b1111) off_cnt++;
            @(negedge clk);
        end
        chk("dbz_dark_cycles", 32'(off_cnt), 32'(EXP_OFF));
        check_digits("dbz", GE, GR, GR, GB);

        // valid held through CONVERT while c changes: only the accepted value shows
        @(negedge clk);
        res_valid = 1'b1; c = 5'b00011; divbyzeroflag = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("ready_low_convert", 32'(res_ready), 32'd0);
        c = 5'b01001;
        @(negedge clk);
        chk("ready_back", 32'(res_ready), 32'd1);
        res_valid = 1'b0;
        check_digits("hold", GB, GB, G3, GB);

        // reset in the middle of a conversion discards it
        @(negedge clk);
        res_valid = 1'b1; c = 5'b11100; signflag = 1'b1; zeroflag = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_an", 32'(an), 32'hF);
        chk("midrst_leds", 32'({zero_led, sign_led}), 32'd0);
        chk("midrst_ready", 32'(res_ready), 32'd1);
        idle_lit = 1'b0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (an != 4'b1111) idle_lit = 1'b1;
        end
        chk("midrst_idle", 32'(idle_lit), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
